// File: rtl/jump_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : jump_controller_if
// Description : Execute-stage redirect bundle between the pipeline and the
//               fetch-PC / jump controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface jump_controller_if;
    logic        stall;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [31:0] alu_out;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        flush;
    logic        link_we;
    logic [31:0] link_data;
    logic        misalign;
    logic [31:0] bad_addr;

    // Pipeline side: presents the executing control transfer, consumes the redirect.
    modport master (
        output stall, br_valid, br_type, alu_out, ex_pc, imm,
        input  pc, flush, link_we, link_data, misalign, bad_addr
    );

    // Controller side.
    modport slave (
        input  stall, br_valid, br_type, alu_out, ex_pc, imm,
        output pc, flush, link_we, link_data, misalign, bad_addr
    );
endinterface
`default_nettype wire

// File: rtl/jump_controller.sv
`default_nettype none
// ============================================================================
// Module      : jump_controller
// Description : Fetch-PC sequencer resolving branches/JAL/JALR with a timed
//               post-redirect flush window, link write-back and misalign trap.
// Revision    : 1.0 - initial release
// ============================================================================
module jump_controller #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    jump_controller_if.slave jc
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [1:0]  c_br_none    = 2'b00;
    localparam logic [1:0]  c_br_branch  = 2'b01;
    localparam logic [1:0]  c_br_jal     = 2'b10;
    localparam logic [1:0]  c_br_jalr    = 2'b11;
    localparam logic [2:0]  c_flush_init = 3'(FLUSH_CYCLES);
    localparam logic [31:0] c_pc_step    = 32'd4;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_link_we;
    logic        w_link_we_next;
    logic [31:0] r_link_data;
    logic [31:0] w_link_data_next;
    logic        r_misalign;
    logic        w_misalign_next;
    logic [31:0] r_bad_addr;
    logic [31:0] w_bad_addr_next;

    logic        w_accept;
    logic        w_is_jump;
    logic        w_cond_taken;
    logic        w_taken;
    logic [31:0] w_target;
    logic        w_target_misaligned;
    logic [31:0] w_pc_seq;

    // ------------------------------------------------------------------------
    // Control-transfer decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_accept     = jc.br_valid && (r_state == ST_RUN);
        w_is_jump    = 1'b0;
        w_cond_taken = 1'b0;
        case (jc.br_type)
            c_br_none:   w_cond_taken = 1'b0;
            c_br_branch: w_cond_taken = jc.alu_out[0];
            c_br_jal: begin
                w_is_jump    = 1'b1;
                w_cond_taken = 1'b1;
            end
            c_br_jalr: begin
                w_is_jump    = 1'b1;
                w_cond_taken = 1'b1;
            end
            default:     w_cond_taken = 1'b0;
        endcase
        w_taken = w_accept && w_cond_taken;
    end

    // JALR drops bit 0 of rs1+imm; everything else is PC-relative.
    always_comb begin
        if (jc.br_type == c_br_jalr) begin
            w_target = {jc.alu_out[31:1], 1'b0};
        end else begin
            w_target = jc.ex_pc + jc.imm;
        end
        w_target_misaligned = |w_target[1:0];
        w_pc_seq            = r_pc + c_pc_step;
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_pc_next        = jc.stall ? r_pc : w_pc_seq;
        w_link_we_next   = 1'b0;
        w_link_data_next = r_link_data;
        w_misalign_next  = 1'b0;
        w_bad_addr_next  = r_bad_addr;

        case (r_state)
            ST_RUN: begin
                // A redirect overrides stall: the fetch stream is being replaced.
                if (w_taken) begin
                    w_state_next = ST_FLUSH;
                    w_cnt_next   = c_flush_init;
                    if (w_target_misaligned) begin
                        w_pc_next       = TRAP_VEC;
                        w_misalign_next = 1'b1;
                        w_bad_addr_next = w_target;
                    end else begin
                        w_pc_next = w_target;
                        if (w_is_jump) begin
                            w_link_we_next   = 1'b1;
                            w_link_data_next = jc.ex_pc + c_pc_step;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // Counter runs down independent of stall; br_valid is ignored here.
                if (r_cnt <= 3'd1) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= 3'd0;
            r_pc        <= RESET_PC;
            r_link_we   <= 1'b0;
            r_link_data <= 32'd0;
            r_misalign  <= 1'b0;
            r_bad_addr  <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_pc        <= w_pc_next;
            r_link_we   <= w_link_we_next;
            r_link_data <= w_link_data_next;
            r_misalign  <= w_misalign_next;
            r_bad_addr  <= w_bad_addr_next;
        end
    end

    assign jc.pc        = r_pc;
    assign jc.flush     = (r_state == ST_FLUSH);
    assign jc.link_we   = r_link_we;
    assign jc.link_data = r_link_data;
    assign jc.misalign  = r_misalign;
    assign jc.bad_addr  = r_bad_addr;

endmodule
`default_nettype wire

// File: tb/tb_jump_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_controller
// Description : Directed + randomized bench for jump_controller against a
//               cycle-level behavioural model of the redirect rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_controller;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC     = 32'h0000_0100;
    localparam int          FLUSH_CYCLES = 2;

    localparam logic [1:0] c_none   = 2'b00;
    localparam logic [1:0] c_branch = 2'b01;
    localparam logic [1:0] c_jal    = 2'b10;
    localparam logic [1:0] c_jalr   = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    int          m_flush_left;
    logic        m_link_we;
    logic [31:0] m_link_data;
    logic        m_mis;
    logic [31:0] m_bad;

    jump_controller_if bus ();

    jump_controller #(
        .RESET_PC    (RESET_PC),
        .TRAP_VEC    (TRAP_VEC),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .jc (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_flush_left = 0;
        m_link_we    = 1'b0;
        m_link_data  = 32'd0;
        m_mis        = 1'b0;
        m_bad        = 32'd0;
    endtask

    // One rising edge of the reference: spec rules evaluated on current inputs.
    task automatic model_step();
        bit          taken;
        bit          jump;
        logic [31:0] tgt;
        taken = 0;
        jump  = (bus.br_type == c_jal) || (bus.br_type == c_jalr);
        if (m_flush_left == 0 && bus.br_valid)
            taken = jump || (bus.br_type == c_branch && bus.alu_out[0]);
        tgt = (bus.br_type == c_jalr) ? (bus.alu_out & 32'hFFFF_FFFE) : (bus.ex_pc + bus.imm);
        m_link_we = 1'b0;
        m_mis     = 1'b0;
        if (taken) begin
            m_flush_left = FLUSH_CYCLES;
            if (tgt % 4 != 0) begin
                m_pc  = TRAP_VEC;
                m_mis = 1'b1;
                m_bad = tgt;
            end else begin
                m_pc = tgt;
                if (jump) begin
                    m_link_we   = 1'b1;
                    m_link_data = bus.ex_pc + 32'd4;
                end
            end
        end else begin
            if (m_flush_left > 0) m_flush_left--;
            if (!bus.stall) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".pc"},        bus.pc,              m_pc);
        check({where, ".flush"},     32'(bus.flush),      32'(m_flush_left > 0));
        check({where, ".link_we"},   32'(bus.link_we),    32'(m_link_we));
        check({where, ".link_data"}, bus.link_data,       m_link_data);
        check({where, ".misalign"},  32'(bus.misalign),   32'(m_mis));
        check({where, ".bad_addr"},  bus.bad_addr,        m_bad);
    endtask

    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        #1;
        compare_all(where);
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] alu,
                         input logic [31:0] epc, input logic [31:0] im, input logic st);
        bus.br_valid = v;
        bus.br_type  = t;
        bus.alu_out  = alu;
        bus.ex_pc    = epc;
        bus.imm      = im;
        bus.stall    = st;
    endtask

    task automatic idle(input logic st);
        drive(1'b0, c_none, 32'd0, 32'd0, 32'd0, st);
    endtask

    initial begin
        logic [31:0] pc_before;
        idle(1'b0);
        model_reset();
        #2;
        compare_all("reset_async");
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset_held");
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch after reset
        for (int i = 0; i < 3; i++) cycle("seq");
        check("seq_pc_c", bus.pc, 32'h0000_000C);

        // Taken branch, then flush window
        drive(1'b1, c_branch, 32'd1, 32'h40, 32'h20, 1'b0);
        cycle("br_taken");
        check("br_target", bus.pc, 32'h60);
        check("br_flush1", 32'(bus.flush), 32'd1);
        idle(1'b0);
        cycle("br_fl1");
        check("br_flush2", 32'(bus.flush), 32'd1);
        cycle("br_fl2");
        check("br_flush_end", 32'(bus.flush), 32'd0);

        // Not-taken branch
        pc_before = m_pc;
        drive(1'b1, c_branch, 32'd0, 32'h40, 32'h20, 1'b0);
        cycle("br_nt");
        check("br_nt_pc", bus.pc, pc_before + 32'd4);

        // Misaligned JALR
        drive(1'b1, c_jalr, 32'h203, 32'h100, 32'h0, 1'b0);
        cycle("jalr_mis");
        check("mis_pc", bus.pc, 32'h100);
        check("mis_pulse", 32'(bus.misalign), 32'd1);
        check("mis_bad", bus.bad_addr, 32'h202);
        idle(1'b0);
        cycle("mis_after");
        check("mis_hold_bad", bus.bad_addr, 32'h202);
        cycle("mis_after2");

        // JAL with link wrap
        drive(1'b1, c_jal, 32'h0, 32'hFFFF_FFFC, 32'h8, 1'b0);
        cycle("jal_wrap");
        check("jal_wrap_pc", bus.pc, 32'h4);
        check("jal_wrap_link", bus.link_data, 32'h0);
        check("jal_wrap_we", 32'(bus.link_we), 32'd1);
        idle(1'b0);
        cycle("jal_after");
        cycle("jal_after2");

        // Redirect beats stall; br_valid in flush ignored
        drive(1'b1, c_jal, 32'h0, 32'h200, 32'h40, 1'b1);
        cycle("stall_jal");
        check("stall_jal_pc", bus.pc, 32'h240);
        drive(1'b1, c_jal, 32'h0, 32'h300, 32'h80, 1'b1);
        cycle("flush_ign");
        check("flush_ign_pc", bus.pc, 32'h240);
        check("flush_ign_we", 32'(bus.link_we), 32'd0);
        idle(1'b1);
        cycle("flush_drop");
        check("flush_drop", 32'(bus.flush), 32'd0);

        // Asynchronous reset during flush
        drive(1'b1, c_jal, 32'h0, 32'h0, 32'h1000, 1'b0);
        cycle("pre_rst");
        idle(1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_pc", bus.pc, RESET_PC);
        check("arst_flush", 32'(bus.flush), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle("post_rst");
        check("post_rst_pc", bus.pc, 32'h4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] epc;
            logic [31:0] im;
            epc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) epc = 32'hFFFF_FFF0 | (epc & 32'hC);
            im = $urandom_range(0, 4) == 0 ? $urandom : ($urandom & 32'h0000_FFFC);
            drive($urandom_range(0, 9) < 5, 2'($urandom_range(0, 3)), $urandom,
                  epc, im, $urandom_range(0, 9) < 3);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jump_controller.md
JUMP_CONTROLLER -- requirements
Module: jump_controller

Interface
REQ-001 Param RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
REQ-002 Param TRAP_VEC, 32'h0000_0100, fetch PC loaded on misaligned jump target.
REQ-003 Param FLUSH_CYCLES, 2, range 1..7, number of cycles flush stays high after a redirect.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 stall  in  1  hold fetch PC when no redirect is pending.
REQ-007 br_valid  in  1  control-transfer instruction present in execute this cycle.
REQ-008 br_type  in  2  00 NONE, 01 BRANCH (conditional), 10 JAL, 11 JALR.
REQ-009 alu_out  in  32  ALU result; BRANCH: bit0 = condition true; JALR: rs1+imm sum.
REQ-010 ex_pc  in  32  PC of the executing instruction.
REQ-011 imm  in  32  sign-extended branch/JAL offset.
REQ-012 pc  out  32  current fetch PC.
REQ-013 flush  out  1  kill fetch/decode instructions younger than the redirect.
REQ-014 link_we  out  1  one-cycle write-enable for rd link value.
REQ-015 link_data  out  32  ex_pc+4 of the accepted JAL/JALR.
REQ-016 misalign  out  1  one-cycle pulse: jump target not 4-byte aligned.
REQ-017 bad_addr  out  32  offending target captured with misalign.

Function
REQ-018 Block SHALL implement FSM {RUN, FLUSH}; br_valid accepted only in RUN.
REQ-019 taken = accepted br_valid and (JAL, JALR, or BRANCH with alu_out[0]=1); br_type NONE or BRANCH with alu_out[0]=0 is not taken.
REQ-020 Target SHALL be ex_pc+imm for BRANCH/JAL and {alu_out[31:1],1'b0} for JALR, 32-bit modulo 2^32.
REQ-021 Taken with target[1:0]==00: at next edge pc<=target, FSM->FLUSH, flush counter<=FLUSH_CYCLES.
REQ-022 Taken with target[1:0]!=00: at next edge pc<=TRAP_VEC, misalign=1 for exactly one cycle, bad_addr<=target, FSM->FLUSH; link_we stays 0.
REQ-023 Aligned taken JAL/JALR: at next edge link_we=1 for one cycle, link_data<=ex_pc+4 (wraps 32'hFFFF_FFFC->0).
REQ-024 Not taken, stall=0: pc<=pc+4, wrapping 32'hFFFF_FFFC->32'h0000_0000.
REQ-025 Not taken, stall=1: pc held.
REQ-026 Redirect SHALL take priority over stall (simultaneous taken and stall: pc loads target).
REQ-027 flush SHALL be high exactly while FSM=FLUSH; counter decrements each cycle regardless of stall; FSM->RUN when counter reaches 1 at edge.
REQ-028 In FLUSH, br_valid SHALL be ignored (no redirect, no link_we, no misalign); pc advances/holds per REQ-024/025.
REQ-029 Redirect latency SHALL be exactly 1 cycle from the br_valid cycle to pc showing target.
REQ-030 bad_addr SHALL hold its value until the next misalign.

Reset
REQ-031 rst=1 SHALL immediately, independent of clk, set pc=RESET_PC, FSM=RUN, flush=0, link_we=0, link_data=0, misalign=0, bad_addr=0, counter=0.
REQ-032 Reset asserted mid-FLUSH SHALL abort the flush; first edge after deassertion behaves as RUN with pc=RESET_PC.

Verification
REQ-033 Reset, stall=0, no br_valid, 3 edges -> pc 0x0,0x4,0x8,0xC; flush=0.
REQ-034 ex_pc=0x40, BRANCH, alu_out=1, imm=0x20 -> next cycle pc=0x60, flush=1 for 2 cycles, link_we=0; with alu_out=0 -> pc+4, flush=0.
REQ-035 ex_pc=0x100, JALR, alu_out=0x203 -> pc=0x202 -> misaligned: pc=0x100 (TRAP_VEC), misalign pulse, bad_addr=0x202, link_we=0.
REQ-036 ex_pc=0xFFFF_FFFC, JAL, imm=0x8 -> pc=0x4, link_we pulse, link_data=0x0.
REQ-037 JAL taken while stall=1, then second br_valid during flush -> pc=target, second ignored, pc held by stall, flush drops after 2 cycles.
REQ-038 Assert rst asynchronously during flush -> pc=0x0, flush=0 before next edge.
